relogio_ajustavel: RTL and testbench
====================================

Name: relogio_ajustavel

Overview:
Parametrised successor to the fixed 24 h seconds/minutes/hours clock top. It keeps its own 1 Hz prescaler, runs BCD counters for HH:MM:SS and drives six 7-segment digits. It adds a selectable 12 h/24 h mode, a PM flag, and a button-driven time-set state machine. It sits at the top of the clock design in place of the fixed clock top.

Parameters:
TICKS_PER_SEC, 50000000, main_clock cycles per second; prescaler counts 0..TICKS_PER_SEC-1 (min 2).
MODE_24H, 1, 1 = 24 h display 00..23; 0 = 12 h display 01..12 with pm flag.

Ports:
main_clock  in  1  system clock; all state on rising edge.
main_reset  in  1  synchronous, active-high reset.
btn_mode    in  1  one-cycle pulse, already debounced; advances set-mode FSM.
btn_inc     in  1  one-cycle pulse, already debounced; increments the field being set.
s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd  out  7 each  7-seg digits, active-low, bit order {g,f,e,d,c,b,a}.
pm          out  1  12 h mode: 1 = PM; tied 0 when MODE_24H=1.
set_state   out  2  00 RUN, 01 SET_H, 10 SET_M.
tick_1hz    out  1  one-cycle pulse when prescaler wraps.

Behaviour:
- Reset is synchronous and active-high; all state is sampled on main_clock.
- Reset values: prescaler 0; FSM RUN; time 00:00:00 (24 h) or 12:00:00 with pm=0 (12 h); tick_1hz 0.
- Reset mid-operation (any state) takes effect at the next edge and overrides all inputs.
- Prescaler:
  - Increments every cycle in RUN.
  - tick_1hz=1 in the cycle where count==TICKS_PER_SEC-1; the count then wraps to 0.
  - Held at 0 while in SET_H/SET_M.
- Time registers are BCD: s_lsd 4 b, s_msd 3 b, m_lsd 4 b, m_msd 3 b, h_lsd 4 b, h_msd 2 b.
- RUN, on each tick:
  - Seconds +1; 59 -> 00 with carry to minutes in the same edge.
  - Minutes 59 -> 00 with carry to hours; all carries ripple within one edge (23:59:59 -> 00:00:00 on a single tick).
- Hours in 24 h mode: 23 -> 00.
- Hours in 12 h mode:
  - Sequence 12,01,..,11,12.
  - 11 -> 12 toggles pm.
  - 12 -> 01 leaves pm unchanged.
- Latency: time registers update on the edge ending the tick cycle. Segment outputs are combinational decodes of those registers, valid in the following cycle.
- FSM transitions on btn_mode: RUN -> SET_H -> SET_M -> RUN.
  - Entering SET_H: seconds are cleared to 00.
  - Leaving SET_M -> RUN: prescaler restarts from 0, so the first tick comes TICKS_PER_SEC cycles later.
- btn_inc in SET_H: hours +1 with the same wrap rules as RUN (including the pm toggle in 12 h). No effect on minutes.
- btn_inc in SET_M: minutes +1, 59 -> 00, no carry into hours.
- btn_inc in RUN is ignored.
- btn_mode and btn_inc in the same cycle: btn_mode wins, btn_inc is dropped.
- No time advance in SET states; a pending tick is discarded.
- Segment decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other code = 1111111 (blank).
- No leading-zero blanking.

Optional Feature:
RELOGIO_BLINK_EN:
- Defined: in SET_H, h_lsd/h_msd alternate between the digit and blank (1111111) every TICKS_PER_SEC/2 cycles. In SET_M, m_lsd/m_msd do the same. A dedicated half-second counter drives the blink; it resets to 0, showing the digit, on entering each SET state.
- Undefined: digits always shown, no blink counter is synthesised.

Test Plan:
1. TICKS_PER_SEC=4, MODE_24H=1: release reset, run 240 cycles -> 00:01:00; tick_1hz pulses at cycles 4,8,..; s_lsd=1000000 after 00:01:00.
2. 24 h rollover: set 23:59 via FSM, return to RUN, 60 ticks -> 00:00:00 on the same edge; h_msd=1000000, h_lsd=1000000.
3. MODE_24H=0:
   - from reset (12:00:00 AM), 11 btn_inc in SET_H -> 11, pm=0;
   - 1 more -> 12, pm=1;
   - 1 more -> 01, pm=1.
4. Set flow: in SET_M at minute 59, btn_inc -> 00 with hours unchanged; btn_mode+btn_inc in the same cycle -> RUN, minutes stay 00; first tick exactly 4 cycles later.
5. Reset mid-SET_H with time 07:23:00 -> next edge: set_state=00, 00:00:00 (or 12:00:00 AM), prescaler 0.
6. RELOGIO_BLINK_EN, TICKS_PER_SEC=4: in SET_H, h_lsd shows digit for 2 cycles, then 1111111 for 2 cycles, repeating; m digits steady.

Source files
------------

// File: rtl/relogio_ajustavel.sv
// Adjustable HH:MM:SS clock: 1 Hz prescaler, BCD time, 12/24 h mode, button time-set FSM, 7-seg outputs.
// Optional blinking of the field being set is enabled by defining RELOGIO_BLINK_EN.
module relogio_ajustavel #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int MODE_24H      = 1
) (
    input  logic       main_clock,
    input  logic       main_reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [6:0] s_lsd,
    output logic [6:0] s_msd,
    output logic [6:0] m_lsd,
    output logic [6:0] m_msd,
    output logic [6:0] h_lsd,
    output logic [6:0] h_msd,
    output logic       pm,
    output logic [1:0] set_state,
    output logic       tick_1hz
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SET_H = 2'b01,
        ST_SET_M = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec_l_q, sec_l_d;
    logic [2:0]    sec_m_q, sec_m_d;
    logic [3:0]    min_l_q, min_l_d;
    logic [2:0]    min_m_q, min_m_d;
    logic [3:0]    hr_l_q, hr_l_d;
    logic [1:0]    hr_m_q, hr_m_d;
    logic          pm_q, pm_d;
    logic          tick_s;
    logic          sec_wrap_s;
    logic          min_wrap_s;
    logic          hr_blank_s;
    logic          min_blank_s;

    // BCD 00..59 increment; {msd[2:0], lsd[3:0]}
    function automatic logic [6:0] sixty_step(input logic [6:0] cur);
        logic [2:0] msd;
        logic [3:0] lsd;
        {msd, lsd} = cur;
        if (msd == 3'd5 && lsd == 4'd9) begin
            msd = 3'd0;
            lsd = 4'd0;
        end else if (lsd == 4'd9) begin
            msd = msd + 3'd1;
            lsd = 4'd0;
        end else begin
            lsd = lsd + 4'd1;
        end
        return {msd, lsd};
    endfunction

    // Hour increment with 24 h wrap or 12 h sequence; {pm, msd[1:0], lsd[3:0]}
    function automatic logic [6:0] hour_step(input logic [6:0] cur);
        logic       pm_v;
        logic [1:0] msd;
        logic [3:0] lsd;
        {pm_v, msd, lsd} = cur;
        if (MODE_24H != 0) begin
            if (msd == 2'd2 && lsd == 4'd3) begin
                msd = 2'd0;
                lsd = 4'd0;
            end else if (lsd == 4'd9) begin
                msd = msd + 2'd1;
                lsd = 4'd0;
            end else begin
                lsd = lsd + 4'd1;
            end
        end else begin
            if (msd == 2'd1 && lsd == 4'd2) begin
                msd = 2'd0;
                lsd = 4'd1;
            end else if (msd == 2'd1 && lsd == 4'd1) begin
                lsd  = 4'd2;
                pm_v = ~pm_v;
            end else if (lsd == 4'd9) begin
                msd = msd + 2'd1;
                lsd = 4'd0;
            end else begin
                lsd = lsd + 4'd1;
            end
        end
        return {pm_v, msd, lsd};
    endfunction

    // Active-low 7-segment decode {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign tick_s     = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    assign sec_wrap_s = ({sec_m_q, sec_l_q} == {3'd5, 4'd9});
    assign min_wrap_s = ({min_m_q, min_l_q} == {3'd5, 4'd9});

    // Next-state: FSM, prescaler and time; btn_mode has priority over btn_inc
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_l_d = sec_l_q;
        sec_m_d = sec_m_q;
        min_l_d = min_l_q;
        min_m_d = min_m_q;
        hr_l_d  = hr_l_q;
        hr_m_d  = hr_m_q;
        pm_d    = pm_q;
        case (state_q)
            ST_RUN: begin
                if (btn_mode) begin
                    state_d = ST_SET_H;
                    presc_d = '0;
                    sec_l_d = 4'd0;
                    sec_m_d = 3'd0;
                end else if (tick_s) begin
                    presc_d            = '0;
                    {sec_m_d, sec_l_d} = sixty_step({sec_m_q, sec_l_q});
                    if (sec_wrap_s) begin
                        {min_m_d, min_l_d} = sixty_step({min_m_q, min_l_q});
                        if (min_wrap_s) begin
                            {pm_d, hr_m_d, hr_l_d} = hour_step({pm_q, hr_m_q, hr_l_q});
                        end else begin
                            hr_l_d = hr_l_q;
                        end
                    end else begin
                        min_l_d = min_l_q;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_SET_H: begin
                presc_d = '0;
                if (btn_mode) begin
                    state_d = ST_SET_M;
                end else if (btn_inc) begin
                    {pm_d, hr_m_d, hr_l_d} = hour_step({pm_q, hr_m_q, hr_l_q});
                end else begin
                    state_d = ST_SET_H;
                end
            end
            ST_SET_M: begin
                presc_d = '0;
                if (btn_mode) begin
                    state_d = ST_RUN;
                end else if (btn_inc) begin
                    {min_m_d, min_l_d} = sixty_step({min_m_q, min_l_q});
                end else begin
                    state_d = ST_SET_M;
                end
            end
            default: begin
                state_d = ST_RUN;
                presc_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge main_clock) begin
        if (main_reset) begin
            state_q <= ST_RUN;
            presc_q <= '0;
            sec_l_q <= 4'd0;
            sec_m_q <= 3'd0;
            min_l_q <= 4'd0;
            min_m_q <= 3'd0;
            hr_l_q  <= (MODE_24H != 0) ? 4'd0 : 4'd2;
            hr_m_q  <= (MODE_24H != 0) ? 2'd0 : 2'd1;
            pm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sec_l_q <= sec_l_d;
            sec_m_q <= sec_m_d;
            min_l_q <= min_l_d;
            min_m_q <= min_m_d;
            hr_l_q  <= hr_l_d;
            hr_m_q  <= hr_m_d;
            pm_q    <= pm_d;
        end
    end

`ifdef RELOGIO_BLINK_EN
    localparam int HALF = (TICKS_PER_SEC / 2 > 1) ? TICKS_PER_SEC / 2 : 1;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] HALF_MAX = BW'(HALF - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    // Half-second blink timer, restarted (digit visible) on every state change
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (state_d != state_q || state_q == ST_RUN) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == HALF_MAX) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    // Blink timer registers
    always_ff @(posedge main_clock) begin
        if (main_reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign hr_blank_s  = (state_q == ST_SET_H) && blink_phase_q;
    assign min_blank_s = (state_q == ST_SET_M) && blink_phase_q;
`else
    assign hr_blank_s  = 1'b0;
    assign min_blank_s = 1'b0;
`endif

    // Segment decode of the time registers, with optional blanking of the field being set
    always_comb begin
        s_lsd = seg7(sec_l_q);
        s_msd = seg7({1'b0, sec_m_q});
        if (min_blank_s) begin
            m_lsd = SEG_BLANK;
            m_msd = SEG_BLANK;
        end else begin
            m_lsd = seg7(min_l_q);
            m_msd = seg7({1'b0, min_m_q});
        end
        if (hr_blank_s) begin
            h_lsd = SEG_BLANK;
            h_msd = SEG_BLANK;
        end else begin
            h_lsd = seg7(hr_l_q);
            h_msd = seg7({2'b00, hr_m_q});
        end
    end

    assign pm        = (MODE_24H != 0) ? 1'b0 : pm_q;
    assign set_state = state_q;
    assign tick_1hz  = tick_s;

endmodule

// File: tb/tb_relogio_ajustavel.sv
// Bench for relogio_ajustavel: a 24 h and a 12 h instance share stimulus; hand vectors plus random run
// against a seconds-of-day reference model.
module tb_relogio_ajustavel;

    localparam int T    = 4;
    localparam int HALF = T / 2;

    logic clk;
    logic rst, mode, inc;

    logic [6:0] s_lsd_a, s_msd_a, m_lsd_a, m_msd_a, h_lsd_a, h_msd_a;
    logic [6:0] s_lsd_b, s_msd_b, m_lsd_b, m_msd_b, h_lsd_b, h_msd_b;
    logic       pm_a, pm_b, tick_a, tick_b;
    logic [1:0] st_a, st_b;

    relogio_ajustavel #(.TICKS_PER_SEC(T), .MODE_24H(1)) dut24 (
        .main_clock(clk), .main_reset(rst), .btn_mode(mode), .btn_inc(inc),
        .s_lsd(s_lsd_a), .s_msd(s_msd_a), .m_lsd(m_lsd_a), .m_msd(m_msd_a),
        .h_lsd(h_lsd_a), .h_msd(h_msd_a), .pm(pm_a), .set_state(st_a), .tick_1hz(tick_a)
    );

    relogio_ajustavel #(.TICKS_PER_SEC(T), .MODE_24H(0)) dut12 (
        .main_clock(clk), .main_reset(rst), .btn_mode(mode), .btn_inc(inc),
        .s_lsd(s_lsd_b), .s_msd(s_msd_b), .m_lsd(m_lsd_b), .m_msd(m_msd_b),
        .h_lsd(h_lsd_b), .h_msd(h_msd_b), .pm(pm_b), .set_state(st_b), .tick_1hz(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state 0 RUN / 1 SET_H / 2 SET_M, hours kept as 0..23
    int m_st, m_presc, m_h, m_m, m_s, m_bn;

    typedef struct {
        logic rst;
        logic mode;
        logic inc;
        int   reps;
        int   st;
        int   h;
        int   mi;
        int   se;
    } vec_t;

    localparam int NV = 30;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] digits(input int v, input bit blank);
        if (blank) return 14'h3FFF;
        return {seg(v / 10), seg(v % 10)};
    endfunction

    function automatic int h12(input int h);
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    function automatic bit blank_field(input int field_st);
`ifdef RELOGIO_BLINK_EN
        return (m_st == field_st) && (((m_bn / HALF) % 2) == 1);
`else
        return (field_st < 0);
`endif
    endfunction

    task automatic model_reset();
        m_st = 0; m_presc = 0; m_h = 0; m_m = 0; m_s = 0; m_bn = 0;
    endtask

    task automatic model_update(input logic r, input logic md, input logic ic);
        int old_st;
        int tod;
        old_st = m_st;
        if (r) begin
            model_reset();
        end else begin
            case (m_st)
                0: begin
                    if (md) begin
                        m_st = 1; m_s = 0; m_presc = 0;
                    end else if (m_presc == T - 1) begin
                        m_presc = 0;
                        tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                        m_h = tod / 3600; m_m = (tod / 60) % 60; m_s = tod % 60;
                    end else begin
                        m_presc++;
                    end
                end
                1: begin
                    if (md) m_st = 2;
                    else if (ic) m_h = (m_h + 1) % 24;
                end
                default: begin
                    if (md) m_st = 0;
                    else if (ic) m_m = (m_m + 1) % 60;
                end
            endcase
            if (m_st != old_st) m_bn = 0;
            else m_bn++;
        end
    endtask

    task automatic compare_all();
        chk("state24", {30'd0, st_a}, m_st);
        chk("state12", {30'd0, st_b}, m_st);
        chk("sec24", {18'd0, s_msd_a, s_lsd_a}, {18'd0, digits(m_s, 1'b0)});
        chk("min24", {18'd0, m_msd_a, m_lsd_a}, {18'd0, digits(m_m, blank_field(2))});
        chk("hour24", {18'd0, h_msd_a, h_lsd_a}, {18'd0, digits(m_h, blank_field(1))});
        chk("pm24", {31'd0, pm_a}, 32'd0);
        chk("sec12", {18'd0, s_msd_b, s_lsd_b}, {18'd0, digits(m_s, 1'b0)});
        chk("min12", {18'd0, m_msd_b, m_lsd_b}, {18'd0, digits(m_m, blank_field(2))});
        chk("hour12", {18'd0, h_msd_b, h_lsd_b}, {18'd0, digits(h12(m_h), blank_field(1))});
        chk("pm12", {31'd0, pm_b}, (m_h >= 12) ? 32'd1 : 32'd0);
    endtask

    task automatic step(input logic r, input logic md, input logic ic);
        logic exp_tick;
        @(negedge clk);
        rst = r; mode = md; inc = ic;
        exp_tick = (m_st == 0) && (m_presc == T - 1);
        chk("tick24", {31'd0, tick_a}, {31'd0, exp_tick});
        chk("tick12", {31'd0, tick_b}, {31'd0, exp_tick});
        @(posedge clk);
        model_update(r, md, ic);
        #1;
        compare_all();
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b0,   2, 0,  0,  0,  0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 240, 0,  0,  1,  0};
        vt[2]  = '{1'b0, 1'b1, 1'b0,   1, 1,  0,  1,  0};
        vt[3]  = '{1'b0, 1'b0, 1'b1,  23, 1, 23,  1,  0};
        vt[4]  = '{1'b0, 1'b1, 1'b0,   1, 2, 23,  1,  0};
        vt[5]  = '{1'b0, 1'b0, 1'b1,  58, 2, 23, 59,  0};
        vt[6]  = '{1'b0, 1'b1, 1'b0,   1, 0, 23, 59,  0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 236, 0, 23, 59, 59};
        vt[8]  = '{1'b0, 1'b0, 1'b0,   4, 0,  0,  0,  0};
        vt[9]  = '{1'b1, 1'b0, 1'b0,   1, 0,  0,  0,  0};
        vt[10] = '{1'b0, 1'b1, 1'b0,   1, 1,  0,  0,  0};
        vt[11] = '{1'b0, 1'b0, 1'b1,  11, 1, 11,  0,  0};
        vt[12] = '{1'b0, 1'b0, 1'b1,   1, 1, 12,  0,  0};
        vt[13] = '{1'b0, 1'b0, 1'b1,   1, 1, 13,  0,  0};
        vt[14] = '{1'b0, 1'b1, 1'b0,   1, 2, 13,  0,  0};
        vt[15] = '{1'b0, 1'b0, 1'b1,  59, 2, 13, 59,  0};
        vt[16] = '{1'b0, 1'b0, 1'b1,   1, 2, 13,  0,  0};
        vt[17] = '{1'b0, 1'b1, 1'b1,   1, 0, 13,  0,  0};
        vt[18] = '{1'b0, 1'b0, 1'b0,   3, 0, 13,  0,  0};
        vt[19] = '{1'b0, 1'b0, 1'b0,   1, 0, 13,  0,  1};
        vt[20] = '{1'b0, 1'b1, 1'b0,   1, 1, 13,  0,  0};
        vt[21] = '{1'b0, 1'b0, 1'b1,  18, 1,  7,  0,  0};
        vt[22] = '{1'b0, 1'b1, 1'b0,   1, 2,  7,  0,  0};
        vt[23] = '{1'b0, 1'b0, 1'b1,  23, 2,  7, 23,  0};
        vt[24] = '{1'b0, 1'b1, 1'b0,   1, 0,  7, 23,  0};
        vt[25] = '{1'b0, 1'b1, 1'b0,   1, 1,  7, 23,  0};
        vt[26] = '{1'b0, 1'b0, 1'b0,   3, 1,  7, 23,  0};
        vt[27] = '{1'b1, 1'b0, 1'b1,   1, 0,  0,  0,  0};
        vt[28] = '{1'b0, 1'b0, 1'b0,   3, 0,  0,  0,  0};
        vt[29] = '{1'b0, 1'b0, 1'b0,   1, 0,  0,  0,  1};

        rst = 1'b1; mode = 1'b0; inc = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        chk("reset_tick", {31'd0, tick_a}, 32'd0);
        chk("reset_h12", {18'd0, h_msd_b, h_lsd_b}, {18'd0, seg(1), seg(2)});

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < vt[i].reps; k++) begin
                step(vt[i].rst, vt[i].mode, vt[i].inc);
            end
            chk($sformatf("vec%0d_state", i), {30'd0, st_a}, vt[i].st);
            chk($sformatf("vec%0d_sec", i), {18'd0, s_msd_a, s_lsd_a}, {18'd0, digits(vt[i].se, 1'b0)});
            chk($sformatf("vec%0d_min", i), {18'd0, m_msd_a, m_lsd_a},
                {18'd0, digits(vt[i].mi, (vt[i].st == 2) && blank_field(2))});
            chk($sformatf("vec%0d_hour24", i), {18'd0, h_msd_a, h_lsd_a},
                {18'd0, digits(vt[i].h, (vt[i].st == 1) && blank_field(1))});
            chk($sformatf("vec%0d_hour12", i), {18'd0, h_msd_b, h_lsd_b},
                {18'd0, digits(h12(vt[i].h), (vt[i].st == 1) && blank_field(1))});
            chk($sformatf("vec%0d_pm12", i), {31'd0, pm_b}, (vt[i].h >= 12) ? 32'd1 : 32'd0);
        end

        for (int n = 0; n < 3000; n++) begin
            logic r, md, ic;
            r  = ($urandom_range(0, 499) == 0);
            md = ($urandom_range(0, 15) == 0);
            ic = ($urandom_range(0, 3) == 0);
            if (m_st == 0 && m_presc == T - 1) md = 1'b0;
            step(r, md, ic);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
